// File: rtl/wm_coin_frontend.sv
// wm_coin_frontend: synchronise/debounce panel inputs, accumulate coin credit, drive refund solenoid (optional OVERPAY_RETURN_EN returns excess coins)
module wm_coin_frontend #(
  parameter int DEBOUNCE_CYCLES     = 16,
  parameter int PRICE               = 4,
  parameter int CREDIT_W            = 4,
  parameter int RETURN_PULSE_CYCLES = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                coin_in,
  input  logic                cancel_in,
  input  logic                lid_in,
  input  logic [2:0]          mode_in,
  input  logic                busy,
  input  logic                cycle_done,
  output logic                coin,
  output logic                cancel,
  output logic                lid,
  output logic                mode_1,
  output logic                mode_2,
  output logic                mode_3,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_return_pulse,
  output logic                refund_active
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(RETURN_PULSE_CYCLES + 1);
  typedef enum logic [1:0] {COLLECT, PAID, LOCKED, REFUND} state_t;
  state_t state, state_nx;
  logic [5:0] raw, s1, s2, db;
  logic [4:0] db_q, ev;
  logic coin_ev, cancel_ev, run, end_ph, dec, load, add_coin, ovp, low_ph;
  logic [2:0] mode_ev, mode;
  logic [TW-1:0] ptmr;
  logic [CREDIT_W-1:0] rcnt, rcnt_nx, credit_nx;
  logic [CREDIT_W+1:0] rsum;
  assign raw = {mode_in, lid_in, cancel_in, coin_in};
  // two-flop synchroniser for every raw input
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end
  for (genvar g = 0; g < 6; g++) begin : g_db
    logic [DW-1:0] cnt;
    // count consecutive cycles the synchronised input disagrees with the debounced level
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        cnt   <= '0;
        db[g] <= 1'b0;
      end else if (s2[g] == db[g]) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        db[g] <= s2[g];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign ev        = {db[5:3], db[1:0]} & ~db_q;
  assign coin_ev   = ev[0];
  assign cancel_ev = ev[1];
  assign mode_ev   = ev[4:2];
  // refund engine and credit bookkeeping
  always_comb begin
    run      = rcnt != '0;
    end_ph   = run && ptmr == TW'(RETURN_PULSE_CYCLES - 1);
    dec      = end_ph && low_ph;
    load     = cancel_ev && credit != '0 && (state == COLLECT || state == PAID);
`ifdef OVERPAY_RETURN_EN
    ovp      = coin_ev && (state == PAID || state == LOCKED);
`else
    ovp      = 1'b0;
`endif
    add_coin = (coin_ev && (state == REFUND || load)) || ovp;
    rsum     = {2'b0, rcnt} + {2'b0, load ? credit : '0} + (CREDIT_W+2)'(add_coin) - (CREDIT_W+2)'(dec);
    rcnt_nx  = rsum > {2'b0, {CREDIT_W{1'b1}}} ? '1 : rsum[CREDIT_W-1:0];
    credit_nx = state == COLLECT ? (load ? '0 : coin_ev ? credit + 1'b1 : credit)
              : (state == PAID && !cancel_ev && !busy) ? credit : '0;
  end
  // datapath registers: credit, pending returns, pulse timer, mode latch
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      credit <= '0;
      rcnt   <= '0;
      ptmr   <= '0;
      low_ph <= 1'b0;
      db_q   <= '0;
      mode   <= 3'b001;
    end else begin
      credit <= credit_nx;
      rcnt   <= rcnt_nx;
      ptmr   <= (!run || end_ph) ? '0 : ptmr + 1'b1;
      low_ph <= !run ? 1'b0 : end_ph ? !low_ph : low_ph;
      db_q   <= {db[5:3], db[1:0]};
      if ((state == COLLECT || state == PAID) && mode_ev != '0)
        mode <= mode_ev[0] ? 3'b001 : mode_ev[1] ? 3'b010 : 3'b100;
    end
  end
  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= COLLECT;
    else          state <= state_nx;
  end
  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: state_nx = load ? REFUND : (coin_ev && credit + 1'b1 == CREDIT_W'(PRICE)) ? PAID : COLLECT;
      PAID:    state_nx = load ? REFUND : busy ? LOCKED : PAID;
      LOCKED:  state_nx = cycle_done ? COLLECT : LOCKED;
      REFUND:  state_nx = (dec && rcnt_nx == '0) ? COLLECT : REFUND;
      default: state_nx = COLLECT;
    endcase
  end
  // FSM and pass-through outputs
  always_comb begin
    coin              = state == PAID || state == LOCKED;
    cancel            = cancel_ev && state != REFUND;
    refund_active     = state == REFUND;
    coin_return_pulse = run && !low_ph;
    lid               = db[2];
    {mode_3, mode_2, mode_1} = mode;
  end
endmodule

// File: tb/tb_wm_coin_frontend.sv
// tb_wm_coin_frontend: directed-vector bench for wm_coin_frontend
module tb_wm_coin_frontend;
  logic clock = 1'b0, reset_n = 1'b0;
  logic coin_in = 0, cancel_in = 0, lid_in = 0, busy = 0, cycle_done = 0;
  logic [2:0] mode_in = '0;
  logic coin, cancel, lid, mode_1, mode_2, mode_3, coin_return_pulse, refund_active;
  logic [3:0] credit;
  int n_vec = 0, n_bad = 0;
  wm_coin_frontend dut (
    .clock(clock), .reset_n(reset_n), .coin_in(coin_in), .cancel_in(cancel_in),
    .lid_in(lid_in), .mode_in(mode_in), .busy(busy), .cycle_done(cycle_done),
    .coin(coin), .cancel(cancel), .lid(lid), .mode_1(mode_1), .mode_2(mode_2),
    .mode_3(mode_3), .credit(credit), .coin_return_pulse(coin_return_pulse),
    .refund_active(refund_active)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 0; coin_in = 0; cancel_in = 0; lid_in = 0; mode_in = '0; busy = 0; cycle_done = 0;
    tick(2);
    reset_n = 1;
  endtask
  task automatic coin_pulse();
    coin_in = 1; tick(20);
    coin_in = 0; tick(20);
  endtask
  task automatic press_mode(input logic [2:0] m);
    mode_in = m; tick(20);
    mode_in = '0; tick(20);
  endtask
  initial begin
    int pulses, high, rcyc, cans;
    logic prev, done;
    tick(3);
    chk("rst_coin", coin, 0);
    chk("rst_credit", credit, 0);
    chk("rst_mode", {mode_3, mode_2, mode_1}, 3'b001);
    chk("rst_refund", {refund_active, coin_return_pulse, cancel, lid}, 0);
    reset_n = 1;
    lid_in = 1; tick(17);
    chk("lid_early", lid, 0);
    tick(1);
    chk("lid_late", lid, 1);
    // bouncing coin then a steady high
    do_reset();
    for (int i = 0; i < 30; i++) begin
      coin_in = ((i / 3) % 2 == 0);
      tick(1);
    end
    chk("bounce_none", credit, 0);
    coin_in = 1; tick(18);
    chk("bounce_before", credit, 0);
    tick(1);
    chk("bounce_one", credit, 1);
    tick(10);
    chk("bounce_held", credit, 1);
    coin_in = 0; tick(20);
    // mode select, paid, locked, done
    do_reset();
    press_mode(3'b110);
    chk("mode_low_wins", {mode_3, mode_2, mode_1}, 3'b010);
    for (int i = 1; i <= 3; i++) begin
      coin_pulse();
      chk("credit_step", credit, i);
      chk("coin_unpaid", coin, 0);
    end
    coin_pulse();
    chk("credit_full", credit, 4);
    chk("coin_paid", coin, 1);
    busy = 1; tick(1); busy = 0;
    chk("locked_credit", credit, 0);
    chk("locked_coin", coin, 1);
    press_mode(3'b100);
    chk("mode_locked", {mode_3, mode_2, mode_1}, 3'b010);
    cans = 0;
    cancel_in = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) cancel_in = 0;
      tick(1);
      cans += int'(cancel);
      if (refund_active) cans += 100;
    end
    chk("locked_cancel", cans, 1);
    chk("locked_hold", coin, 1);
    cycle_done = 1; tick(1); cycle_done = 0;
    chk("done_coin", coin, 0);
    coin_pulse();
    chk("collect_again", credit, 1);
    // three coins then cancel
    do_reset();
    repeat (3) coin_pulse();
    chk("pre_refund", credit, 3);
    cancel_in = 1;
    pulses = 0; high = 0; rcyc = 0; prev = 0; done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick(1);
      if (refund_active) rcyc++;
      if (coin_return_pulse) high++;
      if (coin_return_pulse && !prev) pulses++;
      prev = coin_return_pulse;
      if (rcyc > 0 && !refund_active) done = 1;
      if (rcyc == 1) chk("refund_credit", credit, 0);
    end
    cancel_in = 0;
    chk("refund_done", done, 1);
    chk("refund_pulses", pulses, 3);
    chk("refund_high", high, 24);
    chk("refund_cycles", rcyc, 48);
    chk("refund_exit", {refund_active, coin, credit}, 0);
    tick(20);
    // overpaid coin
    do_reset();
    repeat (4) coin_pulse();
    pulses = 0; prev = 0;
    coin_in = 1;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) coin_in = 0;
      tick(1);
      if (coin_return_pulse && !prev) pulses++;
      prev = coin_return_pulse;
    end
`ifdef OVERPAY_RETURN_EN
    chk("overpay_pulses", pulses, 1);
`else
    chk("overpay_pulses", pulses, 0);
`endif
    chk("overpay_credit", credit, 4);
    chk("overpay_coin", {coin, refund_active}, 2'b10);
    // reset during the second refund pulse
    do_reset();
    press_mode(3'b010);
    repeat (3) coin_pulse();
    cancel_in = 1;
    pulses = 0; prev = 0;
    for (int i = 0; i < 300 && pulses < 2; i++) begin
      tick(1);
      if (coin_return_pulse && !prev) pulses++;
      prev = coin_return_pulse;
    end
    chk("second_pulse", pulses, 2);
    reset_n = 0; cancel_in = 0;
    tick(1);
    chk("mid_rst_outs", {coin, cancel, lid, coin_return_pulse, refund_active}, 0);
    chk("mid_rst_credit", credit, 0);
    chk("mid_rst_mode", {mode_3, mode_2, mode_1}, 3'b001);
    reset_n = 1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      pulses += int'(coin_return_pulse);
    end
    chk("mid_rst_quiet", pulses, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
